// File: rtl/niios_qsys_jtag_scan_master.sv
// Host-side virtual-JTAG scan initiator: one IR+DR command -> UIR, CDR, SHIFT, UDR, RTI -> response.
// Optional NIIOS_JTAG_SCAN_IR_CACHE_EN skips the UIR period when the IR is already loaded.
module niios_qsys_jtag_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir_out,
    output logic                vs_tck,
    output logic                vs_tdi,
    input  logic                vs_tdo,
    output logic [1:0]          vs_ir_in,
    input  logic [1:0]          vs_ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                vs_rti
);

    localparam int unsigned PW = $clog2(2 * TCK_HALF);
    localparam int unsigned BW = $clog2(DR_WIDTH);
    localparam logic [PW-1:0] PH_RISE = PW'(TCK_HALF - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(TCK_HALF);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DR_WIDTH-1:0]   shift_q, shift_d;
    logic [DR_WIDTH-1:0]   cap_q, cap_d;
    logic [1:0]            ir_q, ir_d;
    logic [1:0]            ir_out_q, ir_out_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  tck_q, tck_d;
    logic                  tdi_q, tdi_d;
    logic                  uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
    logic                  cache_hit;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
    logic                  cache_vld_q, cache_vld_d;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        cap_d    = cap_q;
        ir_d     = ir_q;
        ir_out_d = ir_out_q;
        cache_hit = 1'b0;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_hit   = cache_vld_q && (cmd_ir == ir_q);
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = cache_hit ? S_CDR : S_UIR;
                    shift_d = cmd_dr;
                    ir_d    = cmd_ir;
                    phase_d = '0;
                    bit_d   = '0;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
                    cache_vld_d = 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
            end
            default: begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                // Sampling happens on the clk edge that raises tck.
                if (phase_q == PH_RISE) begin
                    if (state_q == S_CDR)   ir_out_d = vs_ir_out;
                    if (state_q == S_SHIFT) cap_d[bit_q] = vs_tdo;
                end
                if (phase_q == PH_LAST) begin
                    case (state_q)
                        S_UIR: state_d = S_CDR;
                        S_CDR: begin
                            state_d = S_SHIFT;
                            bit_d   = '0;
                        end
                        S_SHIFT: begin
                            shift_d = shift_q >> 1;
                            if (bit_q == BIT_LAST) state_d = S_UDR;
                            else                   bit_d   = bit_q + 1'b1;
                        end
                        S_UDR:   state_d = S_RTI;
                        S_RTI:   state_d = S_RESP;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        // Outputs are registered from the next state so they align with state boundaries.
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_q == S_RESP) && (state_d == S_RESP);
        tck_d = (state_d inside {S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI}) && (phase_d >= PH_HIGH);
        tdi_d = (state_d == S_SHIFT) && shift_d[0];
        uir_d = (state_d == S_UIR);
        cdr_d = (state_d == S_CDR);
        sdr_d = (state_d == S_SHIFT);
        udr_d = (state_d == S_UDR);
        rti_d = (state_d == S_RTI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            ir_q        <= '0;
            ir_out_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            ir_q        <= ir_d;
            ir_out_q    <= ir_out_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = cap_q;
    assign rsp_ir_out = ir_out_q;
    assign vs_tck     = tck_q;
    assign vs_tdi     = tdi_q;
    assign vs_ir_in   = ir_q;
    assign vs_uir     = uir_q;
    assign vs_cdr     = cdr_q;
    assign vs_sdr     = sdr_q;
    assign vs_udr     = udr_q;
    assign vs_rti     = rti_q;

endmodule

// File: tb/tb_niios_qsys_jtag_scan_master.sv
// Scoreboard bench for niios_qsys_jtag_scan_master: stimulus pushes expected responses,
// a monitor pops and compares them; a simple shift-register target sits on the TAP side.
module tb_niios_qsys_jtag_scan_master;
    localparam int unsigned DW = 38;
    localparam int unsigned TH = 2;
    localparam int unsigned P  = 2 * TH;
`ifdef NIIOS_JTAG_SCAN_IR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_ir;
    logic [DW-1:0] cmd_dr;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_dr;
    logic [1:0]    rsp_ir_out;
    logic          vs_tck, vs_tdi, vs_tdo;
    logic [1:0]    vs_ir_in, vs_ir_out;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti;

    niios_qsys_jtag_scan_master #(.DR_WIDTH(DW), .TCK_HALF(TH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vs_tck(vs_tck), .vs_tdi(vs_tdi), .vs_tdo(vs_tdo),
        .vs_ir_in(vs_ir_in), .vs_ir_out(vs_ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_rti(vs_rti)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dr;
        logic [1:0]    ir_out;
        logic [1:0]    ir;
        bit            hit;
        int unsigned   acc;
    } exp_t;

    exp_t          sb[$];
    int unsigned   total = 0, bad = 0;
    int unsigned   cyc = 0;
    int unsigned   n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rise;
    int unsigned   tck_idle_bad = 0;
    logic          loop_mode = 1'b1;
    logic [DW-1:0] tgt_sr, tgt_init = '0;
    logic          load_tgl = 1'b0;
    logic [50:0]   all_outs;

    assign vs_tdo = loop_mode ? vs_tdi : tgt_sr[0];
    assign all_outs = {cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vs_tck, vs_tdi, vs_ir_in,
                       vs_uir, vs_cdr, vs_sdr, vs_udr, vs_rti};

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Target DR: shifts tdi in at each tck rise during SDR; tdo is its LSB.
    initial begin : target
        logic seen;
        seen = 1'b0;
        tgt_sr = '0;
        forever begin
            @(posedge vs_tck or load_tgl);
            if (load_tgl !== seen) begin
                tgt_sr = tgt_init;
                seen = load_tgl;
            end else if (vs_sdr) begin
                tgt_sr = {vs_tdi, tgt_sr[DW-1:1]};
            end
        end
    end

    initial begin : counters
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_rise = 0;
            end else begin
                if (vs_uir) n_uir++;
                if (vs_cdr) n_cdr++;
                if (vs_sdr) n_sdr++;
                if (vs_udr) n_udr++;
                if (vs_rti) n_rti++;
                if (vs_tck && !prev) n_rise++;
            end
            prev = vs_tck;
        end
    end

    initial begin : sink
        bit s_in;
        int unsigned stall, nresp;
        s_in = 1'b0; stall = 0; nresp = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (!s_in) begin
                    s_in = 1'b1;
                    stall = (nresp == 1) ? 20 : $urandom_range(0, 3);
                    nresp++;
                end
                if (stall > 0) begin
                    rsp_ready = 1'b0;
                    stall--;
                end else begin
                    rsp_ready = 1'b1;
                end
            end else begin
                s_in = 1'b0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [DW+1:0] snap;
        int unsigned unstable, busy_rdy;
        bit in_resp, after_hs, have;
        in_resp = 1'b0; after_hs = 1'b0; have = 1'b0;
        unstable = 0; busy_rdy = 0; snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_resp = 1'b0;
                after_hs = 1'b0;
            end else begin
                if ((cmd_ready || rsp_valid) && vs_tck) tck_idle_bad++;
                if (after_hs) begin
                    chk("ready_after_handshake", {cmd_ready, rsp_valid}, 2'b10);
                    after_hs = 1'b0;
                end
                if (rsp_valid && !in_resp) begin
                    in_resp = 1'b1;
                    unstable = 0;
                    busy_rdy = 0;
                    snap = {rsp_dr, rsp_ir_out};
                    have = (sb.size() != 0);
                    chk("rsp_expected", have, 1);
                    if (have) begin
                        e = sb[0];
                        chk("latency", cyc - e.acc, (DW + 4 - e.hit) * P + 1);
                        chk("uir_clks", n_uir, e.hit ? 0 : P);
                        chk("cdr_clks", n_cdr, P);
                        chk("sdr_clks", n_sdr, DW * P);
                        chk("udr_clks", n_udr, P);
                        chk("rti_clks", n_rti, P);
                        chk("tck_rises", n_rise, DW + 4 - e.hit);
                    end
                end
                if (in_resp) begin
                    if ({rsp_dr, rsp_ir_out} !== snap) unstable++;
                    if (cmd_ready) busy_rdy++;
                    if (rsp_ready) begin
                        if (have) begin
                            e = sb.pop_front();
                            chk("rsp_dr", rsp_dr, e.dr);
                            chk("rsp_ir_out", rsp_ir_out, e.ir_out);
                            chk("vs_ir_in", vs_ir_in, e.ir);
                        end
                        chk("rsp_stable", unstable, 0);
                        chk("ready_while_busy", busy_rdy, 0);
                        in_resp = 1'b0;
                        after_hs = 1'b1;
                    end
                end
            end
        end
    end

    bit            cache_v = 1'b0;
    logic [1:0]    cache_ir = '0;
    bit            sr_pending = 1'b0;
    logic [DW-1:0] last_dr = '0;

    task automatic issue(input logic [1:0] ir, input logic [DW-1:0] dr, input bit loop,
                         input logic [DW-1:0] sr, input logic [1:0] iro);
        exp_t e;
        int unsigned n;
        n = 0;
        @(posedge clk);
        #1;
        while (!(cmd_ready || rsp_valid) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_wait", cmd_ready || rsp_valid, 1);
        if (sr_pending) chk("target_sr_end", tgt_sr, last_dr);
        sr_pending = 1'b0;
        loop_mode = loop;
        tgt_init  = sr;
        load_tgl  = ~load_tgl;
        vs_ir_out = iro;
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", cmd_ready, 1);
        if (cmd_ready) begin
            e.hit    = CACHE && cache_v && (ir == cache_ir);
            cache_v  = 1'b1;
            cache_ir = ir;
            e.dr     = loop ? dr : sr;
            e.ir_out = iro;
            e.ir     = ir;
            e.acc    = cyc + 1;
            sb.push_back(e);
            last_dr    = dr;
            sr_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin : stimulus
        int unsigned n;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir = '0;
        cmd_dr = '0;
        vs_ir_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);
        chk("tck_after_reset", vs_tck, 0);

        issue(2'b01, 38'h2A_5555_AAAA, 1'b1, rnd_dr(), 2'b00);
        issue(2'b00, '0, 1'b0, 38'h3F_0000_0001, 2'b10);
        issue(2'b11, rnd_dr(), 1'b1, rnd_dr(), 2'b01);
        issue(2'b11, rnd_dr(), 1'b0, rnd_dr(), 2'b11);

        issue(2'b10, rnd_dr(), 1'b0, rnd_dr(), 2'b01);
        n = 0;
        while (!vs_sdr && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_shift", vs_sdr, 1);
        repeat (10 * P) @(posedge clk);
        #1;
        reset = 1'b1;
        void'(sb.pop_back());
        cache_v = 1'b0;
        sr_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", all_outs, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_dr(), 1'($urandom_range(0, 1)), rnd_dr(),
                  2'($urandom_range(0, 3)));
        end

        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        if (sr_pending) chk("target_sr_end", tgt_sr, last_dr);
        chk("tck_idle", tck_idle_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
